directory_msg_responder: RTL and testbench
==========================================

Name: directory_msg_responder

Overview:
- Cache-node-side responder to directory-issued coherence messages: fetch, invalidate, fetch+invalidate.
- Holds a small per-node line table (state, tag, data). Looks up the addressed line, applies the protocol state change and returns a reply (data write-back, invalidate ack, or nack) to the home directory.
- Sits between the node's CPU-side coherence FSM, which populates lines through a local update port, and the directory interconnect.

Parameters:
- NUM_LINES, 4, table entries; must be a power of 2. IDX_W = log2(NUM_LINES).
- TAG_W, 4, tag bits per line.
- DATA_W, 8, data bits per line.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- msg_valid  in  1  directory message present.
- msg_ready  out  1  responder accepts the message this cycle.
- msg_type  in  2  00 none, 01 fetch, 10 invalidate, 11 fetch_invalidate.
- msg_addr  in  IDX_W+TAG_W  address as {tag, index}.
- rsp_valid  out  1  reply present.
- rsp_ready  in  1  directory accepts the reply.
- rsp_type  out  2  01 data write-back, 10 invalidate ack, 11 nack.
- rsp_addr  out  IDX_W+TAG_W  echo of the accepted msg_addr.
- rsp_data  out  DATA_W  line data when rsp_type=01, else 0.
- loc_wr_en  in  1  CPU-side line update request.
- loc_ready  out  1  local update taken this cycle.
- loc_addr  in  IDX_W+TAG_W  address of the local update.
- loc_state  in  2  new state: 01 INVALID, 10 SHARED, 11 MODIFIED.
- loc_data  in  DATA_W  new line data.

Behaviour:
- Reset:
  - Every table entry goes to state 01 (INVALID), tag 0, data 0.
  - FSM goes to IDLE.
  - All outputs go to 0: msg_ready, rsp_valid, rsp_type, rsp_addr, rsp_data, loc_ready.
  - Reset asserted mid-transaction discards the in-flight message and its reply. The table still clears.
- FSM states and transitions:
  - IDLE:
    - msg_ready=1.
    - A handshake (msg_valid & msg_ready) latches msg_type and msg_addr, then goes to LOOKUP.
    - If msg_type=00, the message is consumed with no reply and the FSM stays in IDLE.
  - LOOKUP (1 cycle):
    - Read the entry at the index and compare tags. A hit requires a tag match and state != 01.
    - Compute the reply and commit the state change at the end of this cycle, then go to RESPOND.
  - RESPOND:
    - rsp_valid=1. rsp_type, rsp_addr and rsp_data are held stable until rsp_ready.
    - On rsp_ready, go to IDLE. msg_ready is 0 throughout.
- Latency: message accepted at cycle T gives rsp_valid at T+2. Back-to-back throughput is one message per 3 cycles when rsp_ready is held high.
- Protocol actions (any case not listed is a miss: nack, no change):
  - fetch, MODIFIED hit: write-back with line data; state becomes SHARED.
  - fetch, SHARED hit: nack; no change.
  - invalidate, SHARED hit: invalidate ack; state becomes INVALID.
  - invalidate, MODIFIED hit: write-back with data; state becomes INVALID.
  - invalidate, miss: invalidate ack (idempotent); no change.
  - fetch_invalidate, MODIFIED hit: write-back with data; state becomes INVALID.
  - fetch_invalidate, SHARED hit: invalidate ack; state becomes INVALID.
- Local update port:
  - Accepted only in IDLE when no message handshake occurs that cycle.
  - loc_ready = loc_wr_en & IDLE & !msg_valid. A message wins a same-cycle collision.
  - An accepted update writes tag, state and data at the indexed entry on the next edge.
  - loc_state=00 is written as 01.
- The table is not modified except by LOOKUP commits and accepted local updates.

Optional Feature:
- Macro: RESPONDER_STATS_EN.
- When defined, two extra output ports are added:
  - stat_wb_count (8 bits): number of write-back replies.
  - stat_nack_count (8 bits): number of nack replies.
- Each counter increments once per reply, on the rsp_valid & rsp_ready handshake. Both saturate at 255 and reset to 0.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Shared package coherency_pkg holds:
  - line-state constants INVALID=01, SHARED=10, MODIFIED=11;
  - message codes MSG_NONE/FETCH/INVAL/FETCH_INVAL;
  - reply codes RSP_WB/INV_ACK/NACK.
- One natural sub-module, line_state_table: register array with one combinational read port (index) and one synchronous write port (index, tag, state, data). It owns the reset clear.

Test Plan:
- Local write idx1 tag 3 MODIFIED data A5; fetch {3,1} -> rsp_valid at T+2, rsp_type 01, rsp_data A5. Line 1 is SHARED (a follow-up fetch gives nack).
- Local write idx2 tag 5 SHARED; invalidate {5,2} -> rsp_type 10, rsp_data 0, line 2 INVALID; repeat invalidate -> rsp_type 10 again.
- Fetch_invalidate {7,0} with entry 0 holding tag 6 MODIFIED -> nack 11, entry unchanged (a fetch on {6,0} still returns data).
- Hold rsp_ready=0 for 5 cycles during RESPOND -> rsp_* stable, msg_ready=0, a second msg_valid is not accepted; release -> IDLE, then the second message is accepted.
- msg_valid and loc_wr_en in the same IDLE cycle -> msg_ready=1, loc_ready=0. Assert reset during LOOKUP -> next cycle rsp_valid=0 and all entries INVALID.
- With RESPONDER_STATS_EN: 260 write-backs -> stat_wb_count=255 and nack count unchanged.

Source files
------------

// File: rtl/coherency_pkg.sv
// Shared coherence encodings for the directory-message responder,
// plus the table that maps (message, lookup result) to a reply and a state change.
package coherency_pkg;

    localparam logic [1:0] LINE_INVALID  = 2'b01;
    localparam logic [1:0] LINE_SHARED   = 2'b10;
    localparam logic [1:0] LINE_MODIFIED = 2'b11;

    localparam logic [1:0] MSG_NONE        = 2'b00;
    localparam logic [1:0] MSG_FETCH       = 2'b01;
    localparam logic [1:0] MSG_INVAL       = 2'b10;
    localparam logic [1:0] MSG_FETCH_INVAL = 2'b11;

    localparam logic [1:0] RSP_WB      = 2'b01;
    localparam logic [1:0] RSP_INV_ACK = 2'b10;
    localparam logic [1:0] RSP_NACK    = 2'b11;

    typedef enum logic [1:0] {
        FSM_IDLE    = 2'd0,
        FSM_LOOKUP  = 2'd1,
        FSM_RESPOND = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic [1:0] rsp_type;
        logic       send_data;
        logic       wr_en;
        logic [1:0] new_state;
    } action_t;

    // Anything not matched below is a miss: nack, table untouched.
    function automatic action_t decide_action(input logic [1:0] msg_type,
                                              input logic       hit,
                                              input logic [1:0] line_state);
        action_t act;
        act.rsp_type  = RSP_NACK;
        act.send_data = 1'b0;
        act.wr_en     = 1'b0;
        act.new_state = line_state;
        case (msg_type)
            MSG_FETCH: begin
                if (hit && line_state == LINE_MODIFIED) begin
                    act.rsp_type  = RSP_WB;
                    act.send_data = 1'b1;
                    act.wr_en     = 1'b1;
                    act.new_state = LINE_SHARED;
                end
            end
            MSG_INVAL: begin
                act.rsp_type = RSP_INV_ACK;
                if (hit) begin
                    act.wr_en     = 1'b1;
                    act.new_state = LINE_INVALID;
                    if (line_state == LINE_MODIFIED) begin
                        act.rsp_type  = RSP_WB;
                        act.send_data = 1'b1;
                    end
                end
            end
            MSG_FETCH_INVAL: begin
                if (hit) begin
                    act.wr_en     = 1'b1;
                    act.new_state = LINE_INVALID;
                    act.rsp_type  = (line_state == LINE_MODIFIED) ? RSP_WB : RSP_INV_ACK;
                    act.send_data = (line_state == LINE_MODIFIED);
                end
            end
            default: ;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/line_state_table.sv
// Per-node coherence line table: combinational read by index, one synchronous
// write port; reset clears every entry to INVALID with zero tag and data.
module line_state_table
    import coherency_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 8,
    localparam int IDX_W    = $clog2(NUM_LINES)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [1:0]        o_rd_state,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [1:0]        i_wr_state,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [TAG_W-1:0]  r_tag   [NUM_LINES];
    logic [1:0]        r_state [NUM_LINES];
    logic [DATA_W-1:0] r_data  [NUM_LINES];

    // NOTE: the array is reset explicitly because a cleared table (all INVALID)
    // is architectural state, so this stays in flops rather than a RAM macro.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_tag[i]   <= '0;
                r_state[i] <= LINE_INVALID;
                r_data[i]  <= '0;
            end
        end else if (i_wr_en) begin
            r_tag[i_wr_idx]   <= i_wr_tag;
            r_state[i_wr_idx] <= i_wr_state;
            r_data[i_wr_idx]  <= i_wr_data;
        end
    end

    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_state = r_state[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/directory_msg_responder.sv
// Cache-node responder to directory fetch/invalidate messages (IDLE->LOOKUP->RESPOND).
// Optional reply counters are built in when RESPONDER_STATS_EN is defined.
module directory_msg_responder
    import coherency_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 8,
    localparam int IDX_W    = $clog2(NUM_LINES)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    input  logic [1:0]             msg_type,
    input  logic [IDX_W+TAG_W-1:0] msg_addr,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_type,
    output logic [IDX_W+TAG_W-1:0] rsp_addr,
    output logic [DATA_W-1:0]      rsp_data,
    input  logic                   loc_wr_en,
    output logic                   loc_ready,
    input  logic [IDX_W+TAG_W-1:0] loc_addr,
    input  logic [1:0]             loc_state,
    input  logic [DATA_W-1:0]      loc_data
`ifdef RESPONDER_STATS_EN
    ,
    output logic [7:0]             stat_wb_count,
    output logic [7:0]             stat_nack_count
`endif
);

    localparam int ADDR_W = IDX_W + TAG_W;

    fsm_state_t        r_state;
    logic [1:0]        r_msg_type;
    logic [ADDR_W-1:0] r_msg_addr;
    logic              r_rsp_valid;
    logic [1:0]        r_rsp_type;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [DATA_W-1:0] r_rsp_data;

    logic [TAG_W-1:0]  w_rd_tag;
    logic [1:0]        w_rd_state;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_idle;
    logic              w_hit;
    logic              w_msg_fire;
    action_t           w_act;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [TAG_W-1:0]  w_wr_tag;
    logic [1:0]        w_wr_state;
    logic [DATA_W-1:0] w_wr_data;

    // Ready signals are gated by reset so every output reads 0 while reset is held.
    assign w_idle     = (r_state == FSM_IDLE);
    assign msg_ready  = w_idle & ~reset;
    assign loc_ready  = loc_wr_en & w_idle & ~msg_valid & ~reset;
    assign w_msg_fire = msg_valid & msg_ready;

    assign w_hit = (w_rd_tag == r_msg_addr[ADDR_W-1:IDX_W]) && (w_rd_state != LINE_INVALID);
    assign w_act = decide_action(r_msg_type, w_hit, w_rd_state);

    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        w_wr_en    = loc_ready;
        w_wr_idx   = loc_addr[IDX_W-1:0];
        w_wr_tag   = loc_addr[ADDR_W-1:IDX_W];
        w_wr_state = (loc_state == 2'b00) ? LINE_INVALID : loc_state;
        w_wr_data  = loc_data;
        if (r_state == FSM_LOOKUP) begin
            w_wr_en    = w_act.wr_en;
            w_wr_idx   = r_msg_addr[IDX_W-1:0];
            w_wr_tag   = w_rd_tag;
            w_wr_state = w_act.new_state;
            w_wr_data  = w_rd_data;
        end
    end

    line_state_table #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W),
        .DATA_W    (DATA_W)
    ) u_table (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_rd_idx   (r_msg_addr[IDX_W-1:0]),
        .o_rd_tag   (w_rd_tag),
        .o_rd_state (w_rd_state),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_wr_idx),
        .i_wr_tag   (w_wr_tag),
        .i_wr_state (w_wr_state),
        .i_wr_data  (w_wr_data)
    );

    // NOTE: state and outputs use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= FSM_IDLE;
            r_msg_type  <= MSG_NONE;
            r_msg_addr  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_type  <= '0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                FSM_IDLE: begin
                    if (w_msg_fire && msg_type != MSG_NONE) begin
                        r_msg_type <= msg_type;
                        r_msg_addr <= msg_addr;
                        r_state    <= FSM_LOOKUP;
                    end
                end
                FSM_LOOKUP: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_type  <= w_act.rsp_type;
                    r_rsp_addr  <= r_msg_addr;
                    r_rsp_data  <= w_act.send_data ? w_rd_data : '0;
                    r_state     <= FSM_RESPOND;
                end
                FSM_RESPOND: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_type  <= '0;
                        r_rsp_addr  <= '0;
                        r_rsp_data  <= '0;
                        r_state     <= FSM_IDLE;
                    end
                end
                default: r_state <= FSM_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_type  = r_rsp_type;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_data  = r_rsp_data;

`ifdef RESPONDER_STATS_EN
    logic [7:0] r_stat_wb;
    logic [7:0] r_stat_nack;
    logic       w_rsp_fire;

    assign w_rsp_fire = r_rsp_valid & rsp_ready;

    // Saturating counters, one step per completed reply.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_wb   <= '0;
            r_stat_nack <= '0;
        end else if (w_rsp_fire) begin
            if (r_rsp_type == RSP_WB && r_stat_wb != 8'hFF)
                r_stat_wb <= r_stat_wb + 8'd1;
            if (r_rsp_type == RSP_NACK && r_stat_nack != 8'hFF)
                r_stat_nack <= r_stat_nack + 8'd1;
        end
    end

    assign stat_wb_count   = r_stat_wb;
    assign stat_nack_count = r_stat_nack;
`endif

endmodule

// File: tb/tb_directory_msg_responder.sv
// Directed self-checking bench for directory_msg_responder (default parameters).
// Stats scenario is compiled in when RESPONDER_STATS_EN is defined.
module tb_directory_msg_responder;

    localparam logic [1:0] E_WB    = 2'b01;
    localparam logic [1:0] E_ACK   = 2'b10;
    localparam logic [1:0] E_NACK  = 2'b11;
    localparam logic [1:0] S_SH    = 2'b10;
    localparam logic [1:0] S_MOD   = 2'b11;
    localparam logic [1:0] M_NONE  = 2'b00;
    localparam logic [1:0] M_FETCH = 2'b01;
    localparam logic [1:0] M_INV   = 2'b10;
    localparam logic [1:0] M_FINV  = 2'b11;

    logic       clock = 1'b0;
    logic       reset;
    logic       msg_valid;
    logic       msg_ready;
    logic [1:0] msg_type;
    logic [5:0] msg_addr;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_type;
    logic [5:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       loc_wr_en;
    logic       loc_ready;
    logic [5:0] loc_addr;
    logic [1:0] loc_state;
    logic [7:0] loc_data;
`ifdef RESPONDER_STATS_EN
    logic [7:0] stat_wb_count;
    logic [7:0] stat_nack_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    directory_msg_responder dut (
        .clock     (clock),
        .reset     (reset),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_type  (msg_type),
        .msg_addr  (msg_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_type  (rsp_type),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data),
        .loc_wr_en (loc_wr_en),
        .loc_ready (loc_ready),
        .loc_addr  (loc_addr),
        .loc_state (loc_state),
        .loc_data  (loc_data)
`ifdef RESPONDER_STATS_EN
        ,
        .stat_wb_count   (stat_wb_count),
        .stat_nack_count (stat_nack_count)
`endif
    );

    function automatic logic [5:0] mk(input logic [3:0] tag, input logic [1:0] idx);
        return {tag, idx};
    endfunction

    task automatic local_write(input logic [1:0] idx, input logic [3:0] tag,
                               input logic [1:0] st, input logic [7:0] d);
        @(negedge clock);
        loc_wr_en = 1'b1;
        loc_addr  = mk(tag, idx);
        loc_state = st;
        loc_data  = d;
        @(negedge clock);
        loc_wr_en = 1'b0;
    endtask

    // Issues one message from IDLE and waits (bounded) for the reply; lat counts
    // cycles from the accept cycle to the first cycle with rsp_valid.
    task automatic transact(input logic [1:0] t, input logic [5:0] a,
                            output logic v, output logic [1:0] rt,
                            output logic [5:0] ra, output logic [7:0] rd,
                            output int lat);
        int n;
        @(negedge clock);
        msg_valid = 1'b1;
        msg_type  = t;
        msg_addr  = a;
        @(negedge clock);
        msg_valid = 1'b0;
        msg_type  = M_NONE;
        n = 1;
        while (!rsp_valid && n < 8) begin
            @(negedge clock);
            n++;
        end
        v   = rsp_valid;
        rt  = rsp_type;
        ra  = rsp_addr;
        rd  = rsp_data;
        lat = n;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        msg_valid = 1'b0;
        msg_type  = M_NONE;
        msg_addr  = '0;
        rsp_ready = 1'b1;
        loc_wr_en = 1'b1;
        loc_addr  = '0;
        loc_state = S_MOD;
        loc_data  = 8'hEE;
        repeat (3) @(negedge clock);
        checks++;
        if ({msg_ready, rsp_valid, rsp_type, rsp_addr, rsp_data, loc_ready} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {msg_ready, rsp_valid, rsp_type, rsp_addr, rsp_data, loc_ready});
        end
`ifdef RESPONDER_STATS_EN
        checks++;
        if ({stat_wb_count, stat_nack_count} !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats: got %h want 0", {stat_wb_count, stat_nack_count});
        end
`endif
        loc_wr_en = 1'b0;
        reset     = 1'b0;
        @(negedge clock);
        checks++;
        if ({msg_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_idle: got ready/valid %b want 10", {msg_ready, rsp_valid});
        end
    endtask

    task automatic test_fetch_modified;
        logic v; logic [1:0] rt; logic [5:0] ra; logic [7:0] rd; int lat;
        local_write(2'd1, 4'd3, S_MOD, 8'hA5);
        transact(M_FETCH, mk(4'd3, 2'd1), v, rt, ra, rd, lat);
        checks++;
        if ({v, rt, ra, rd} !== {1'b1, E_WB, mk(4'd3, 2'd1), 8'hA5}) begin
            errors++;
            $display("FAIL fetch_mod: got v=%b t=%b a=%h d=%h want v=1 t=01 a=0d d=a5", v, rt, ra, rd);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL fetch_latency: got %0d want 2", lat);
        end
        transact(M_FETCH, mk(4'd3, 2'd1), v, rt, ra, rd, lat);
        checks++;
        if ({v, rt, rd} !== {1'b1, E_NACK, 8'h00}) begin
            errors++;
            $display("FAIL fetch_shared_nack: got v=%b t=%b d=%h want v=1 t=11 d=00", v, rt, rd);
        end
    endtask

    task automatic test_none_msg;
        logic seen;
        @(negedge clock);
        msg_valid = 1'b1;
        msg_type  = M_NONE;
        msg_addr  = mk(4'd3, 2'd1);
        @(negedge clock);
        msg_valid = 1'b0;
        checks++;
        if (msg_ready !== 1'b1) begin
            errors++;
            $display("FAIL none_stays_idle: got msg_ready=%b want 1", msg_ready);
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clock);
            seen = seen | rsp_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL none_no_reply: got rsp_valid seen=%b want 0", seen);
        end
    endtask

    task automatic test_invalidate;
        logic v; logic [1:0] rt; logic [5:0] ra; logic [7:0] rd; int lat;
        local_write(2'd2, 4'd5, S_SH, 8'h3C);
        transact(M_INV, mk(4'd5, 2'd2), v, rt, ra, rd, lat);
        checks++;
        if ({v, rt, rd} !== {1'b1, E_ACK, 8'h00}) begin
            errors++;
            $display("FAIL inval_shared: got v=%b t=%b d=%h want v=1 t=10 d=00", v, rt, rd);
        end
        transact(M_INV, mk(4'd5, 2'd2), v, rt, ra, rd, lat);
        checks++;
        if ({v, rt, rd} !== {1'b1, E_ACK, 8'h00}) begin
            errors++;
            $display("FAIL inval_repeat: got v=%b t=%b d=%h want v=1 t=10 d=00", v, rt, rd);
        end
        transact(M_FINV, mk(4'd5, 2'd2), v, rt, ra, rd, lat);
        checks++;
        if ({v, rt} !== {1'b1, E_NACK}) begin
            errors++;
            $display("FAIL inval_left_invalid: got v=%b t=%b want v=1 t=11", v, rt);
        end
    endtask

    task automatic test_inval_modified;
        logic v; logic [1:0] rt; logic [5:0] ra; logic [7:0] rd; int lat;
        local_write(2'd3, 4'd2, S_MOD, 8'h99);
        transact(M_INV, mk(4'd2, 2'd3), v, rt, ra, rd, lat);
        checks++;
        if ({v, rt, rd} !== {1'b1, E_WB, 8'h99}) begin
            errors++;
            $display("FAIL inval_mod_wb: got v=%b t=%b d=%h want v=1 t=01 d=99", v, rt, rd);
        end
        transact(M_FINV, mk(4'd2, 2'd3), v, rt, ra, rd, lat);
        checks++;
        if (rt !== E_NACK) begin
            errors++;
            $display("FAIL inval_mod_after: got t=%b want 11", rt);
        end
        local_write(2'd3, 4'd4, S_MOD, 8'h77);
        transact(M_FINV, mk(4'd4, 2'd3), v, rt, ra, rd, lat);
        checks++;
        if ({v, rt, rd} !== {1'b1, E_WB, 8'h77}) begin
            errors++;
            $display("FAIL finv_mod_wb: got v=%b t=%b d=%h want v=1 t=01 d=77", v, rt, rd);
        end
        transact(M_FINV, mk(4'd4, 2'd3), v, rt, ra, rd, lat);
        checks++;
        if (rt !== E_NACK) begin
            errors++;
            $display("FAIL finv_mod_after: got t=%b want 11", rt);
        end
        local_write(2'd3, 4'd4, S_SH, 8'h66);
        transact(M_FINV, mk(4'd4, 2'd3), v, rt, ra, rd, lat);
        checks++;
        if ({v, rt, rd} !== {1'b1, E_ACK, 8'h00}) begin
            errors++;
            $display("FAIL finv_shared_ack: got v=%b t=%b d=%h want v=1 t=10 d=00", v, rt, rd);
        end
    endtask

    task automatic test_tag_miss;
        logic v; logic [1:0] rt; logic [5:0] ra; logic [7:0] rd; int lat;
        local_write(2'd0, 4'd6, S_MOD, 8'h5A);
        transact(M_FINV, mk(4'd7, 2'd0), v, rt, ra, rd, lat);
        checks++;
        if ({v, rt, ra, rd} !== {1'b1, E_NACK, mk(4'd7, 2'd0), 8'h00}) begin
            errors++;
            $display("FAIL tag_miss_nack: got v=%b t=%b a=%h d=%h want v=1 t=11 a=1c d=00", v, rt, ra, rd);
        end
        transact(M_FETCH, mk(4'd6, 2'd0), v, rt, ra, rd, lat);
        checks++;
        if ({v, rt, rd} !== {1'b1, E_WB, 8'h5A}) begin
            errors++;
            $display("FAIL tag_miss_unchanged: got v=%b t=%b d=%h want v=1 t=01 d=5a", v, rt, rd);
        end
        local_write(2'd0, 4'd6, 2'b00, 8'hFF);
        transact(M_FINV, mk(4'd6, 2'd0), v, rt, ra, rd, lat);
        checks++;
        if (rt !== E_NACK) begin
            errors++;
            $display("FAIL loc_state00_invalid: got t=%b want 11", rt);
        end
    endtask

    task automatic test_backpressure;
        logic [16:0] first;
        logic        stable;
        local_write(2'd1, 4'd9, S_MOD, 8'hC3);
        @(negedge clock);
        rsp_ready = 1'b0;
        msg_valid = 1'b1;
        msg_type  = M_FETCH;
        msg_addr  = mk(4'd9, 2'd1);
        @(negedge clock);
        msg_valid = 1'b0;
        @(negedge clock);
        first = {rsp_valid, rsp_type, rsp_addr, rsp_data};
        checks++;
        if (first !== {1'b1, E_WB, mk(4'd9, 2'd1), 8'hC3}) begin
            errors++;
            $display("FAIL stall_first: got %h want %h", first, {1'b1, E_WB, mk(4'd9, 2'd1), 8'hC3});
        end
        msg_valid = 1'b1;
        msg_type  = M_INV;
        msg_addr  = mk(4'd9, 2'd1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if ({rsp_valid, rsp_type, rsp_addr, rsp_data} !== first || msg_ready !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got rsp=%h ready=%b want rsp=%h ready=0",
                     {rsp_valid, rsp_type, rsp_addr, rsp_data}, msg_ready, first);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        checks++;
        if ({msg_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL stall_release: got ready/valid %b want 10", {msg_ready, rsp_valid});
        end
        @(negedge clock);
        msg_valid = 1'b0;
        checks++;
        if (msg_ready !== 1'b0) begin
            errors++;
            $display("FAIL second_accepted: got msg_ready=%b want 0", msg_ready);
        end
        @(negedge clock);
        checks++;
        if ({rsp_valid, rsp_type, rsp_addr} !== {1'b1, E_ACK, mk(4'd9, 2'd1)}) begin
            errors++;
            $display("FAIL second_reply: got v=%b t=%b a=%h want v=1 t=10 a=25", rsp_valid, rsp_type, rsp_addr);
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] pattern;
        @(negedge clock);
        msg_valid = 1'b1;
        msg_type  = M_FETCH;
        msg_addr  = mk(4'd15, 2'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            pattern[i] = rsp_valid;
        end
        msg_valid = 1'b0;
        checks++;
        if (pattern !== 9'b010010010) begin
            errors++;
            $display("FAIL back_to_back: got rsp_valid pattern %b want 010010010", pattern);
        end
    endtask

    task automatic test_collision;
        logic v; logic [1:0] rt; logic [7:0] rd; int n;
        @(negedge clock);
        msg_valid = 1'b1;
        msg_type  = M_FETCH;
        msg_addr  = mk(4'd10, 2'd2);
        loc_wr_en = 1'b1;
        loc_addr  = mk(4'd10, 2'd2);
        loc_state = S_MOD;
        loc_data  = 8'h11;
        #1;
        checks++;
        if ({msg_ready, loc_ready} !== 2'b10) begin
            errors++;
            $display("FAIL collision_ready: got msg/loc ready %b want 10", {msg_ready, loc_ready});
        end
        @(negedge clock);
        msg_valid = 1'b0;
        loc_wr_en = 1'b0;
        n = 1;
        while (!rsp_valid && n < 8) begin
            @(negedge clock);
            n++;
        end
        v  = rsp_valid;
        rt = rsp_type;
        rd = rsp_data;
        checks++;
        if ({v, rt, rd} !== {1'b1, E_NACK, 8'h00}) begin
            errors++;
            $display("FAIL collision_no_write: got v=%b t=%b d=%h want v=1 t=11 d=00", v, rt, rd);
        end
    endtask

    task automatic test_reset_mid;
        logic v; logic [1:0] rt; logic [5:0] ra; logic [7:0] rd; int lat;
        for (int i = 0; i < 4; i++)
            local_write(2'(i), 4'(i + 1), S_MOD, 8'(8'h10 + i));
        @(negedge clock);
        msg_valid = 1'b1;
        msg_type  = M_FETCH;
        msg_addr  = mk(4'd1, 2'd0);
        @(negedge clock);
        msg_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        checks++;
        if ({rsp_valid, msg_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_outputs: got valid/ready %b want 00", {rsp_valid, msg_ready});
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            transact(M_FETCH, mk(4'(i + 1), 2'(i)), v, rt, ra, rd, lat);
            checks++;
            if ({v, rt, rd} !== {1'b1, E_NACK, 8'h00}) begin
                errors++;
                $display("FAIL reset_mid_cleared_%0d: got v=%b t=%b d=%h want v=1 t=11 d=00", i, v, rt, rd);
            end
        end
    endtask

`ifdef RESPONDER_STATS_EN
    task automatic test_stats;
        logic v; logic [1:0] rt; logic [5:0] ra; logic [7:0] rd; int lat;
        logic [7:0] nack_before;
        nack_before = stat_nack_count;
        checks++;
        if (nack_before !== 8'd4) begin
            errors++;
            $display("FAIL stats_nack_count: got %0d want 4", nack_before);
        end
        for (int i = 0; i < 260; i++) begin
            local_write(2'd0, 4'd1, S_MOD, 8'(i));
            transact(M_FETCH, mk(4'd1, 2'd0), v, rt, ra, rd, lat);
        end
        @(negedge clock);
        checks++;
        if ({stat_wb_count, stat_nack_count} !== {8'd255, nack_before}) begin
            errors++;
            $display("FAIL stats_saturate: got wb=%0d nack=%0d want wb=255 nack=%0d",
                     stat_wb_count, stat_nack_count, nack_before);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_fetch_modified;
        test_none_msg;
        test_invalidate;
        test_inval_modified;
        test_tag_miss;
        test_backpressure;
        test_back_to_back;
        test_collision;
        test_reset_mid;
`ifdef RESPONDER_STATS_EN
        test_stats;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
